// File: rtl/game_pkg.sv
// Shared game definitions: direction codes, bar FSM encoding, playfield defaults.
package game_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_L = 2'd1,
    ST_MOVE_R = 2'd2
  } bar_state_e;

  localparam int unsigned PF_POS_W       = 10;
  localparam int unsigned PF_START_POS   = 300;
  localparam int unsigned PF_MIN_POS     = 0;
  localparam int unsigned PF_MAX_POS     = 640;
  localparam int unsigned PF_BAR_WIDTH   = 80;
  localparam int unsigned PF_ACCEL_TICKS = 8;
  localparam int unsigned PF_MAX_MULT    = 4;

endpackage

// File: rtl/bar_speed_ramp.sv
// Speed multiplier ramp for the bar: grows while one direction is held.
// The mult register holds the multiplier for the next tick of the current run,
// so tick n of a run (1-based) moves with min(1 + (n-1)/ACCEL_TICKS, MAX_MULT).
module bar_speed_ramp
  import game_pkg::*;
#(
  parameter int unsigned ACCEL_TICKS = PF_ACCEL_TICKS,
  parameter int unsigned MAX_MULT    = PF_MAX_MULT,
  parameter int unsigned MW          = $clog2(MAX_MULT + 1)
) (
  input  logic          clk_in,
  input  logic          restart,
  input  logic          tick,
  input  logic          same_dir,
  output logic [MW-1:0] mult
);

  localparam int unsigned AW = $clog2(ACCEL_TICKS + 1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_TICKS - 1);
  localparam logic [MW-1:0] MULT_MAX = MW'(MAX_MULT);

  logic [AW-1:0] acc_cnt;
  logic [AW-1:0] acc_base;
  logic [MW-1:0] mult_base;
  logic [AW-1:0] acc_d;
  logic [MW-1:0] mult_d;

  // Advance the run by one tick; a fresh run starts from acc=0, mult=1
  always_comb begin
    acc_base  = acc_cnt;
    mult_base = mult;
    acc_d     = acc_cnt;
    mult_d    = mult;
    if (tick) begin
      if (!same_dir) begin
        acc_base  = '0;
        mult_base = MW'(1);
      end
      if (acc_base == ACC_LAST) begin
        acc_d  = '0;
        mult_d = (mult_base == MULT_MAX) ? MULT_MAX : mult_base + MW'(1);
      end else begin
        acc_d  = acc_base + AW'(1);
        mult_d = mult_base;
      end
    end
  end

  // Ramp state registers with synchronous restart
  always_ff @(posedge clk_in) begin
    if (restart) begin
      acc_cnt <= '0;
      mult    <= MW'(1);
    end else begin
      acc_cnt <= acc_d;
      mult    <= mult_d;
    end
  end

endmodule

// File: rtl/bar_motion_ctrl.sv
// Bar (paddle) horizontal position controller with speed ramp and wall clamping.
module bar_motion_ctrl
  import game_pkg::*;
#(
  parameter int unsigned W           = PF_POS_W,
  parameter int unsigned START_POS   = PF_START_POS,
  parameter int unsigned MIN_POS     = PF_MIN_POS,
  parameter int unsigned MAX_POS     = PF_MAX_POS,
  parameter int unsigned BAR_WIDTH   = PF_BAR_WIDTH,
  parameter int unsigned ACCEL_TICKS = PF_ACCEL_TICKS,
  parameter int unsigned MAX_MULT    = PF_MAX_MULT
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         new_game,
  input  logic         frame_tick,
  input  logic [3:0]   direction,
  input  logic [W-1:0] step,
  output logic [W-1:0] movement,
  output logic         at_left,
  output logic         at_right,
  output logic         moving
);

  localparam int unsigned MW = $clog2(MAX_MULT + 1);
  localparam int unsigned DW = W + 3;
  localparam int unsigned SW = W + 4;
  localparam logic [W-1:0] MIN_P     = W'(MIN_POS);
  localparam logic [W-1:0] RIGHT_LIM = W'(MAX_POS - BAR_WIDTH);
  localparam logic [W-1:0] START_P   = W'(START_POS);

  // Parameter sanity: bad values stop elaboration
  if (MAX_POS < BAR_WIDTH || MAX_POS - BAR_WIDTH < MIN_POS ||
      MAX_POS - BAR_WIDTH >= (1 << W)) begin : g_bad_field
    $fatal(1, "bar_motion_ctrl: playfield does not fit MIN_POS..MAX_POS-BAR_WIDTH in W bits");
  end
  if (START_POS < MIN_POS || START_POS > MAX_POS - BAR_WIDTH) begin : g_bad_start
    $fatal(1, "bar_motion_ctrl: START_POS outside MIN_POS..MAX_POS-BAR_WIDTH");
  end
  if (ACCEL_TICKS < 1 || MAX_MULT < 1 || MAX_MULT > 7) begin : g_bad_ramp
    $fatal(1, "bar_motion_ctrl: ACCEL_TICKS must be >=1 and MAX_MULT in 1..7");
  end

  bar_state_e    state_q;
  bar_state_e    state_d;
  logic [W-1:0]  pos_d;
  logic          dir_r;
  logic          dir_l;
  logic          same_dir;
  logic          restart;
  logic [MW-1:0] mult;
  logic [MW-1:0] mult_sel;
  logic [DW-1:0] delta;
  logic [SW-1:0] right_sum;
  logic [DW-1:0] left_room;
  logic [W-1:0]  right_pos;
  logic [W-1:0]  left_pos;

  assign restart  = reset | new_game;
  assign dir_r    = (direction == DIR_RIGHT);
  assign dir_l    = (direction == DIR_LEFT);
  assign same_dir = frame_tick &&
                    ((dir_r && state_q == ST_MOVE_R) || (dir_l && state_q == ST_MOVE_L));
  assign mult_sel = same_dir ? mult : MW'(1);

  bar_speed_ramp #(
    .ACCEL_TICKS (ACCEL_TICKS),
    .MAX_MULT    (MAX_MULT),
    .MW          (MW)
  ) u_ramp (
    .clk_in   (clk_in),
    .restart  (restart),
    .tick     (frame_tick),
    .same_dir (same_dir),
    .mult     (mult)
  );

  // Candidate positions for a right or left move, clamped to the playfield
  always_comb begin
    delta     = DW'(step) * DW'(mult_sel);
    right_sum = SW'(movement) + SW'(delta);
    left_room = DW'(movement - MIN_P);
    right_pos = (right_sum > SW'(RIGHT_LIM)) ? RIGHT_LIM : W'(right_sum);
    left_pos  = (delta > left_room) ? MIN_P : movement - W'(delta);
  end

  // Next state and next position; everything holds without a frame tick
  always_comb begin
    state_d = state_q;
    pos_d   = movement;
    if (frame_tick) begin
      if (dir_r) begin
        state_d = ST_MOVE_R;
        pos_d   = right_pos;
      end else if (dir_l) begin
        state_d = ST_MOVE_L;
        pos_d   = left_pos;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State, position and flags; flags derive from next values so they are never stale
  always_ff @(posedge clk_in) begin
    if (restart) begin
      state_q  <= ST_IDLE;
      movement <= START_P;
      at_left  <= (START_P == MIN_P);
      at_right <= (START_P == RIGHT_LIM);
      moving   <= 1'b0;
    end else begin
      state_q  <= state_d;
      movement <= pos_d;
      at_left  <= (pos_d == MIN_P);
      at_right <= (pos_d == RIGHT_LIM);
      moving   <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_bar_motion_ctrl.sv
// Self-checking bench for bar_motion_ctrl: directed scenarios then random traffic
// against a run-length based reference model.
module tb_bar_motion_ctrl;

  localparam int unsigned W     = 10;
  localparam int          START = 300;
  localparam int          MINP  = 0;
  localparam int          RLIM  = 640 - 80;
  localparam int          ACCEL = 8;
  localparam int          MMAX  = 4;

  logic         clk_in = 1'b0;
  logic         reset = 1'b1;
  logic         new_game = 1'b0;
  logic         frame_tick = 1'b0;
  logic [3:0]   direction = 4'b0000;
  logic [W-1:0] step = '0;
  logic [W-1:0] movement;
  logic         at_left;
  logic         at_right;
  logic         moving;

  int checks = 0;
  int errors = 0;

  // Reference model: position plus the current run (direction code and length)
  int m_pos = START;
  int m_run_dir = 0;
  int m_run_n = 0;

  bar_motion_ctrl dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .new_game   (new_game),
    .frame_tick (frame_tick),
    .direction  (direction),
    .step       (step),
    .movement   (movement),
    .at_left    (at_left),
    .at_right   (at_right),
    .moving     (moving)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ng, input bit tk, input int dir, input int stp);
    int m;
    int d;
    if (rst || ng) begin
      m_pos = START;
      m_run_dir = 0;
      m_run_n = 0;
    end else if (tk) begin
      if (dir == 1 || dir == 2) begin
        if (m_run_dir == dir) m_run_n++;
        else begin
          m_run_dir = dir;
          m_run_n = 1;
        end
        m = 1 + (m_run_n - 1) / ACCEL;
        if (m > MMAX) m = MMAX;
        d = stp * m;
        if (dir == 1) m_pos = (m_pos + d > RLIM) ? RLIM : m_pos + d;
        else          m_pos = (d > m_pos - MINP) ? MINP : m_pos - d;
      end else begin
        m_run_dir = 0;
        m_run_n = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pos"}, 32'(movement), 32'(m_pos));
    check({tag, ".left"}, 32'(at_left), 32'(m_pos == MINP));
    check({tag, ".right"}, 32'(at_right), 32'(m_pos == RLIM));
    check({tag, ".moving"}, 32'(moving), 32'(m_run_dir != 0));
  endtask

  // Drive one cycle, clock it, update the model and compare 1 time unit after the edge
  task automatic cycle(input string tag, input bit rst, input bit ng, input bit tk,
                       input logic [3:0] dir, input int stp);
    reset = rst;
    new_game = ng;
    frame_tick = tk;
    direction = dir;
    step = W'(stp);
    @(posedge clk_in);
    #1;
    model_edge(rst, ng, tk, int'(dir), stp);
    check_model(tag);
  endtask

  initial begin
    // Reset held two cycles
    @(negedge clk_in);
    cycle("rst0", 1, 0, 0, 4'b0000, 4);
    cycle("rst1", 1, 0, 0, 4'b0000, 4);
    check("rst_pos", 32'(movement), 32'd300);
    check("rst_moving", 32'(moving), 32'd0);

    // Right ramp: eight ticks of 4, ninth tick of 8
    for (int i = 0; i < 9; i++) begin
      cycle("ramp_r", 0, 0, 1, 4'b0001, 4);
      if (i == 7) check("ramp_tick8", 32'(movement), 32'd332);
    end
    check("ramp_tick9", 32'(movement), 32'd340);
    check("ramp_moving", 32'(moving), 32'd1);

    // Right wall clamp
    cycle("rst_a", 1, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cycle("wall_r", 0, 0, 1, 4'b0001, 100);
    check("wall_r_pos", 32'(movement), 32'd560);
    check("wall_r_flag", 32'(at_right), 32'd1);

    // Left wall clamp, no wrap
    cycle("ng_b", 0, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 4; i++) cycle("wall_l", 0, 0, 1, 4'b0010, 100);
    check("wall_l_pos", 32'(movement), 32'd0);
    check("wall_l_flag", 32'(at_left), 32'd1);

    // Reversal after ten right ticks moves by exactly step
    cycle("rst_c", 1, 0, 0, 4'b0000, 0);
    for (int i = 0; i < 10; i++) cycle("rev_r", 0, 0, 1, 4'b0001, 4);
    check("rev_r_pos", 32'(movement), 32'd348);
    cycle("rev_l", 0, 0, 1, 4'b0010, 4);
    check("rev_l_pos", 32'(movement), 32'd344);
    cycle("bad_dir3", 0, 0, 1, 4'b0011, 4);
    check("bad_dir3_pos", 32'(movement), 32'd344);
    check("bad_dir3_mv", 32'(moving), 32'd0);
    cycle("bad_dir4", 0, 0, 1, 4'b0100, 4);
    check("bad_dir4_pos", 32'(movement), 32'd344);

    // No frame tick: nothing moves
    for (int i = 0; i < 20; i++) cycle("no_tick", 0, 0, 0, 4'b0001, 4);
    check("no_tick_pos", 32'(movement), 32'd344);

    // Reset mid-ramp kills residual speed
    for (int i = 0; i < 10; i++) cycle("mid_r", 0, 0, 1, 4'b0001, 4);
    cycle("mid_rst", 1, 0, 1, 4'b0001, 4);
    check("mid_rst_pos", 32'(movement), 32'd300);
    cycle("mid_after", 0, 0, 1, 4'b0001, 4);
    check("mid_after_pos", 32'(movement), 32'd304);

    // Zero step: ramp advances, position holds
    for (int i = 0; i < 9; i++) cycle("step0", 0, 0, 1, 4'b0001, 0);
    check("step0_pos", 32'(movement), 32'd304);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] d;
      int sel;
      int stp;
      bit rst;
      bit ng;
      bit tk;
      sel = int'($urandom_range(0, 9));
      d = (sel < 4) ? 4'b0001 : (sel < 8) ? 4'b0010 : 4'($urandom_range(0, 15));
      stp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 12));
      rst = ($urandom_range(0, 99) == 0);
      ng  = ($urandom_range(0, 99) == 0);
      tk  = ($urandom_range(0, 2) != 0);
      cycle("rand", rst, ng, tk, d, stp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
